uart_rx_frame_ctrl: RTL and testbench

//  Frame controller sitting behind uart_rx. Consumes its byte stream (data_recieved pulse + databyte),

---
 rtl/uart_frame_pkg.sv | 19 +
 rtl/uart_frame_buf.sv | 24 ++
 rtl/uart_rx_frame_ctrl.sv | 140 ++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared encodings for the UART receive frame controller.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [7:0] DEFAULT_SOF = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: DEPTH x 8 register file, one synchronous write port, one async read port.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [DEPTH-1:0][7:0] mem;

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (we && waddr == AW'(i)) mem[i] <= wdata;
  end

  // Address space is one wider than DEPTH; out-of-range reads return zero.
  assign rdata = (raddr < AW'(DEPTH)) ? mem[raddr] : 8'h00;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame parser behind uart_rx: [SOF][LEN][payload][CHK], payload released only after CHK verifies.
// Optional inter-byte timeout enabled by defining UART_RX_FRAME_TIMEOUT_EN.
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE     = DEFAULT_SOF,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int IW = $clog2(MAX_LEN + 1);

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CLKS < 2) begin : g_bad_param
    $error("uart_rx_frame_ctrl: MAX_LEN must be 1..255 and TIMEOUT_CLKS >= 2");
  end

  state_t        state, state_nx;
  logic [7:0]    len, chk_acc, rd_data;
  logic [IW-1:0] wr_idx, rd_idx;
  logic          buf_we, ok_nx, err_nx, tmo_hit, accept;
  logic [1:0]    code_nx;

  assign accept    = out_valid & out_ready;
  assign busy      = (state != HUNT);
  assign out_valid = (state == DRAIN);
  assign out_data  = out_valid ? rd_data : 8'h00;
  assign out_last  = out_valid && (8'(rd_idx) == len - 8'd1);

`ifdef UART_RX_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS);
  logic [TW-1:0] tmo_cnt;
  logic          in_frame;

  assign in_frame = (state == LEN) || (state == PAYLOAD) || (state == CHK);
  assign tmo_hit  = in_frame && !rx_valid && (tmo_cnt == TW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk) begin
    if (rst || rx_valid || !in_frame) tmo_cnt <= '0;
    else                              tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ok_nx    = 1'b0;
    err_nx   = 1'b0;
    code_nx  = err_code;
    buf_we   = 1'b0;
    case (state)
      HUNT: if (rx_valid && rx_byte == SOF_BYTE) state_nx = LEN;
      LEN: if (rx_valid) begin
        if (rx_byte > 8'(MAX_LEN)) begin
          err_nx   = 1'b1;
          code_nx  = ERR_LEN;
          state_nx = HUNT;
        end else if (rx_byte == 8'h00) state_nx = CHK;
        else                           state_nx = PAYLOAD;
      end
      PAYLOAD: if (rx_valid) begin
        buf_we = 1'b1;
        if (8'(wr_idx) == len - 8'd1) state_nx = CHK;
      end
      CHK: if (rx_valid) begin
        if (rx_byte == chk_acc) begin
          ok_nx    = 1'b1;
          state_nx = (len != 8'h00) ? DRAIN : HUNT;
        end else begin
          err_nx   = 1'b1;
          code_nx  = ERR_CHK;
          state_nx = HUNT;
        end
      end
      DRAIN: if (accept && out_last) state_nx = HUNT;
      default: state_nx = HUNT;
    endcase
    // Timeout only fires on cycles without a byte, so it never races a decision above.
    if (tmo_hit) begin
      err_nx   = 1'b1;
      code_nx  = ERR_TMO;
      state_nx = HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len       <= 8'h00;
      chk_acc   <= 8'h00;
      wr_idx    <= '0;
      rd_idx    <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      frame_ok  <= ok_nx;
      frame_err <= err_nx;
      err_code  <= code_nx;
      if (state == LEN && rx_valid) begin
        len     <= rx_byte;
        chk_acc <= rx_byte;
        wr_idx  <= '0;
      end
      if (buf_we) begin
        chk_acc <= chk_acc ^ rx_byte;
        wr_idx  <= wr_idx + 1'b1;
      end
      if (state == CHK)  rd_idx <= '0;
      else if (accept)   rd_idx <= rd_idx + 1'b1;
    end
  end

  uart_frame_buf #(.DEPTH(MAX_LEN), .AW(IW)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_idx),
    .wdata (rx_byte),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Randomized bench for uart_rx_frame_ctrl against a frame-level reference model.
module tb_uart_rx_frame_ctrl;

  localparam int MAX_LEN = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       out_ready = 1'b1;
  logic       out_valid, out_last, frame_ok, frame_err, busy;
  logic [7:0] out_data;
  logic [1:0] err_code;

  uart_rx_frame_ctrl #(.SOF_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Ready modes: 0 always ready, 1 random, 2 pattern 1,0,0,1, 3 never ready.
  int rdy_mode = 0;
  int rdy_cnt  = 0;
  always @(posedge clk) begin
    #1;
    rdy_cnt++;
    case (rdy_mode)
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = (rdy_cnt % 4 == 0) || (rdy_cnt % 4 == 3);
      3:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: collects accepted bytes, pulses and checks stall stability.
  byte unsigned got_q[$];
  int           last_pos[$];
  int           n_ok_seen = 0, n_err_seen = 0;
  logic [1:0]   seen_code = 2'd0;
  logic         prev_stall = 1'b0;
  logic [7:0]   prev_data = 8'h00;
  logic         prev_last = 1'b0;

  always @(negedge clk) begin
    if (rst) prev_stall = 1'b0;
    else begin
      if (frame_ok) n_ok_seen++;
      if (frame_err) begin
        n_err_seen++;
        seen_code = err_code;
      end
      if (frame_ok || frame_err) check("ok_err_excl", 32'(frame_ok & frame_err), 0);
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 1);
        check("stall_data", 32'(out_data), 32'(prev_data));
        check("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        if (out_last) last_pos.push_back(got_q.size() - 1);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic clear_mon();
    got_q.delete();
    last_pos.delete();
    n_ok_seen  = 0;
    n_err_seen = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check("idle_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  // Reference model: a frame of pl_q with LEN field len_f is accepted iff len_f<=MAX_LEN
  // and the check byte equals LEN ^ xor(payload); accepted payload comes out in order.
  byte unsigned pl_q[$];
  byte unsigned junk_q[$];

  task automatic send_frame(input int len_f, input logic [7:0] chk_flip);
    logic [7:0] chk;
    foreach (junk_q[i]) send_byte(junk_q[i], $urandom_range(0, 2));
    send_byte(8'hA5, $urandom_range(0, 2));
    send_byte(8'(len_f), $urandom_range(0, 2));
    if (len_f <= MAX_LEN) begin
      chk = 8'(len_f);
      foreach (pl_q[i]) begin
        chk ^= pl_q[i];
        send_byte(pl_q[i], $urandom_range(0, 2));
      end
      send_byte(chk ^ chk_flip, 0);
    end
  endtask

  task automatic score(input string tag, input int len_f, input logic [7:0] chk_flip);
    bit exp_ok;
    int n;
    exp_ok = (len_f <= MAX_LEN) && (chk_flip == 8'h00);
    check({tag, "_n_ok"}, 32'(n_ok_seen), 32'(exp_ok));
    check({tag, "_n_err"}, 32'(n_err_seen), 32'(!exp_ok));
    if (!exp_ok) check({tag, "_err_code"}, 32'(seen_code), (len_f > MAX_LEN) ? 2 : 1);
    n = exp_ok ? len_f : 0;
    check({tag, "_n_out"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      check({tag, "_data"}, 32'(got_q[i]), 32'(pl_q[i]));
    check({tag, "_n_last"}, 32'(last_pos.size()), (exp_ok && len_f > 0) ? 1 : 0);
    if (last_pos.size() == 1) check({tag, "_last_pos"}, 32'(last_pos[0]), 32'(len_f - 1));
  endtask

  task automatic run_frame(input string tag, input int len_f, input logic [7:0] chk_flip);
    clear_mon();
    send_frame(len_f, chk_flip);
    wait_idle();
    score(tag, len_f, chk_flip);
  endtask

  task automatic fill_rand(input int n);
    pl_q.delete();
    for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom));
  endtask

  initial begin
    logic [7:0] b;
    int len_f;
    logic [7:0] flip;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_frame_ok", 32'(frame_ok), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_busy", 32'(busy), 0);

    // Directed: good frame, bad CHK, oversize LEN, empty frame with junk.
    pl_q = '{8'h11, 8'h22, 8'h33};
    junk_q.delete();
    run_frame("good3", 3, 8'h00);
    run_frame("badchk", 3, 8'h17);
    pl_q.delete();
    run_frame("len17", 17, 8'h00);
    pl_q = '{8'h11, 8'h22, 8'h33};
    run_frame("after_len17", 3, 8'h00);
    pl_q.delete();
    junk_q = '{8'h00, 8'hFF};
    run_frame("len0", 0, 8'h00);
    junk_q.delete();
    pl_q = '{8'hA5, 8'hA5};
    run_frame("sof_as_data", 2, 8'h00);
    pl_q.delete();
    for (int i = 0; i < MAX_LEN; i++) pl_q.push_back(8'(i * 7 + 1));
    run_frame("maxlen", MAX_LEN, 8'h00);

    // Stalled drain with bytes arriving during DRAIN, released with pattern 1,0,0,1.
    clear_mon();
    rdy_mode = 3;
    pl_q = '{8'h5C, 8'hA5, 8'h3E};
    send_frame(3, 8'h00);
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    check("drain_busy", 32'(busy), 1);
    rdy_cnt  = 0;
    rdy_mode = 2;
    wait_idle();
    score("drain", 3, 8'h00);
    rdy_mode = 0;
    pl_q = '{8'h01, 8'h02};
    run_frame("after_drain", 2, 8'h00);

    // Reset in the middle of a frame: no pulses, outputs back to reset values.
    pl_q = '{8'h11, 8'h22, 8'h33};
    run_frame("pre_rst_bad", 3, 8'h40);
    clear_mon();
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_err_code", 32'(err_code), 0);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_out_data", 32'(out_data), 0);
    repeat (4) @(negedge clk);
    check("mid_rst_pulses", 32'(n_ok_seen + n_err_seen), 0);
    check("mid_rst_no_out", 32'(got_q.size()), 0);
    pl_q = '{8'h9A, 8'hBC, 8'hDE};
    run_frame("after_rst", 3, 8'h00);

    // Randomized frames with random junk, lengths, corruption and backpressure.
    for (int f = 0; f < 40; f++) begin
      junk_q.delete();
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        do b = 8'($urandom); while (b == 8'hA5);
        junk_q.push_back(b);
      end
      len_f = ($urandom_range(0, 9) == 0) ? $urandom_range(MAX_LEN + 1, 255) : $urandom_range(0, MAX_LEN);
      flip  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      fill_rand((len_f <= MAX_LEN) ? len_f : 0);
      rdy_mode = $urandom_range(0, 1);
      run_frame("rand", len_f, flip);
    end
    rdy_mode = 0;
    junk_q.delete();

`ifdef UART_RX_FRAME_TIMEOUT_EN
    clear_mon();
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    for (int t = 0; t < 1100 && n_err_seen == 0; t++) @(negedge clk);
    check("tmo_n_err", 32'(n_err_seen), 1);
    check("tmo_code", 32'(seen_code), 3);
    check("tmo_busy", 32'(busy), 0);
    pl_q = '{8'h11, 8'h22, 8'h33};
    run_frame("after_tmo", 3, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
